// File: rtl/sample_accumulator.sv
// sample_accumulator: sums NUM_SAMPLES unsigned 16-bit samples through an
// adder_16bit and presents the total with a sticky carry-out flag.
// Ports: clk, rst (sync, active-high), start, in_valid/in_data/in_ready,
//        out_valid/out_ready/out_sum/out_overflow, busy, sample_count.
// Build option: define SAMPLE_ACCUM_SATURATE_EN to clamp the total at 16'hFFFF.

module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'b0, carry_in};
endmodule

module sample_accumulator #(
    parameter int NUM_SAMPLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_sum,
    output logic        out_overflow,
    output logic        busy,
    output logic [7:0]  sample_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(NUM_SAMPLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] acc;
    logic [15:0] acc_next;
    logic [15:0] add_sum;
    logic        add_carry;
    logic [7:0]  count;
    logic        ovf_flag;
    logic        beat;

    adder_16bit u_adder (
        .a        (acc),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_carry)
    );

    assign beat = (state == ACCUM) && in_valid;

`ifdef SAMPLE_ACCUM_SATURATE_EN
    // A carry can only come from a real overflow, so clamping here keeps
    // the total pinned at all-ones for the rest of the run.
    assign acc_next = add_carry ? 16'hFFFF : add_sum;
`else
    assign acc_next = add_sum;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (beat && count == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= 16'd0;
            count    <= 8'd0;
            ovf_flag <= 1'b0;
        end else if (state == IDLE && start) begin
            acc      <= 16'd0;
            count    <= 8'd0;
            ovf_flag <= 1'b0;
        end else if (beat) begin
            acc      <= acc_next;
            count    <= count + 8'd1;
            ovf_flag <= ovf_flag | add_carry;
        end
    end

    assign in_ready     = (state == ACCUM);
    assign out_valid    = (state == DONE);
    assign busy         = (state == ACCUM) || (state == DONE);
    assign out_sum      = acc;
    assign out_overflow = ovf_flag;
    assign sample_count = count;

endmodule

// File: tb/tb_sample_accumulator.sv
// tb_sample_accumulator: randomized scoreboard bench for sample_accumulator.
// Expected results come from plain integer sums of each run's samples.

module tb_sample_accumulator;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_overflow;
    logic        busy;
    logic [7:0]  sample_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    sample_accumulator #(.NUM_SAMPLES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .busy         (busy),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed at the edge following a negedge where
    // out_valid and out_ready are both high.
    logic [15:0] held_sum;
    logic        held_v = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (held_v) check("hold_sum", out_sum, held_sum);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none",
                             out_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("result_sum", out_sum, e.sum);
                    check("result_ovf", out_overflow, e.ovf);
                    check("result_count", sample_count, N);
                end
                held_v = 1'b0;
            end else begin
                held_v   = 1'b1;
                held_sum = out_sum;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [15:0] s[$]);
        exp_t   e;
        longint tot = 0;
        foreach (s[i]) tot += s[i];
        e.ovf = (tot > 65535);
`ifdef SAMPLE_ACCUM_SATURATE_EN
        e.sum = e.ovf ? 16'hFFFF : 16'(tot);
`else
        e.sum = 16'(tot);
`endif
        return e;
    endfunction

    // One complete run: start, feed samples with random gaps (during which
    // junk data and stray start pulses are driven), then backpressure.
    task automatic run(input logic [15:0] s[$], input int gap_max,
                       input int hold);
        exp_q.push_back(model(s));
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_ready_after_start", {busy, in_ready}, 2'b11);
        foreach (s[i]) begin
            int g = $urandom_range(0, gap_max);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                start    = 1'($urandom_range(0, 1));
                step();
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = s[i];
            step();
            in_valid = 1'b0;
            check("count_after_beat", sample_count, i + 1);
        end
        check("latency_out_valid", out_valid, 1'b1);
        check("in_ready_in_done", in_ready, 1'b0);
        for (int k = 0; k < hold; k++) step();
        check("valid_after_hold", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_after_accept", {busy, out_valid}, 2'b00);
    endtask

    initial begin
        logic [15:0] s[$];
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_outputs",
              {in_ready, out_valid, out_sum, out_overflow, busy, sample_count},
              29'd0);

        // Samples offered while idle are not consumed.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_in_ready", in_ready, 1'b0);
            check("idle_count", sample_count, 0);
        end
        in_valid = 1'b0;

        s = '{16'd1, 16'd2, 16'd3, 16'd4};
        run(s, 0, 0);

        s = '{16'hFFF0, 16'h0020, 16'h0000, 16'h0000};
        run(s, 0, 0);

        // Back-to-back: start in the cycle right after acceptance.
        s = '{16'd1, 16'd1, 16'd1, 16'd1};
        run(s, 0, 0);

        s = '{16'd5, 16'd6, 16'd7, 16'd0};
        run(s, 2, 5);

        // Reset mid-run discards the partial total.
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd4;
        step();
        in_data = 16'd5;
        step();
        in_valid = 1'b0;
        check("partial_sum", out_sum, 16'd9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset_outputs",
              {in_ready, out_valid, out_sum, out_overflow, busy, sample_count},
              29'd0);
        s = '{16'd1, 16'd1, 16'd1, 16'd1};
        run(s, 0, 0);

        for (int r = 0; r < 12; r++) begin
            s = {};
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) s.push_back(16'($urandom));
                else s.push_back(16'($urandom_range(0, 4000)));
            end
            run(s, 3, $urandom_range(0, 4));
        end

        step();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
